col_norm_seq: RTL and testbench

- Sequencer directly upstream of the shared CORDIC unit in the OMP datapath.
- Accepts a column or residual vector as a stream of Q14 samples and accumulates the sum of squares.
- Drives the CORDIC in square-root mode to obtain the L2 norm, then (optionally) in division mode to obtain 1/norm.
- The normalisation stage consumes both results.

---
 rtl/col_norm_seq.sv | 216 +++++++++++++++++++++
 tb/tb_col_norm_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/col_norm_seq.sv
// rtl/col_norm_seq.sv - sum-of-squares accumulator and CORDIC sequencer for column L2 norm and optional 1/norm (COL_NORM_INV_EN)
module col_norm_seq #(
    parameter int DATA_W   = 19,
    parameter int FRAC     = 14,
    parameter int VEC_LEN  = 32,
    parameter int SQRT_LAT = 13,
    parameter int DIV_LAT  = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        norm_out,
    output logic [DATA_W-1:0]        inv_norm_out,
    output logic                     sat_flag,
    output logic                     div0_flag,
    output logic                     cordic_en,
    output logic                     cordic_sel,
    output logic                     cordic_result_sel,
    output logic [DATA_W-1:0]        cordic_din,
    input  logic [DATA_W-1:0]        cordic_dout
);

    localparam int ACC_W   = 2 * DATA_W;
    localparam int CNT_W   = $clog2(VEC_LEN) + 1;
    localparam int MAX_LAT = (SQRT_LAT > DIV_LAT) ? SQRT_LAT : DIV_LAT;
    localparam int WAIT_W  = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(VEC_LEN - 1);
    localparam logic [WAIT_W-1:0] SQ_DONE_CNT = WAIT_W'(SQRT_LAT);
    localparam logic [WAIT_W-1:0] DV_DONE_CNT = WAIT_W'(DIV_LAT);
    localparam logic [DATA_W-1:0] SAT_MAX     = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_DV_ISSUE,
        S_DV_WAIT,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WAIT_W-1:0]  wcnt, wcnt_n;
    logic               sat_w, sat_n;
    logic               div0_w, div0_n;
    logic [DATA_W-1:0]  norm_r, norm_n;
    logic [DATA_W-1:0]  din_n;
`ifdef COL_NORM_INV_EN
    logic [DATA_W-1:0]  inv_r, inv_n;
    logic               dv_phase;
`endif

    // Square in full precision, then drop FRAC bits so the sum stays Q14.
    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] sq;
    logic [ACC_W-1:0]        sq_scaled;
    logic [ACC_W-1:0]        acc_sum;
    logic                    acc_sum_sat;

    assign data_ext    = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign sq          = data_ext * data_ext;
    assign sq_scaled   = sq >>> FRAC;
    assign acc_sum     = acc + sq_scaled;
    assign acc_sum_sat = acc_sum > {{DATA_W{1'b0}}, SAT_MAX};

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        wcnt_n  = wcnt;
        sat_n   = sat_w;
        div0_n  = div0_w;
        norm_n  = norm_r;
        din_n   = cordic_din;
`ifdef COL_NORM_INV_EN
        inv_n   = inv_r;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ACC;
                    acc_n   = '0;
                    cnt_n   = '0;
                    sat_n   = 1'b0;
                    div0_n  = 1'b0;
                end
            end
            S_ACC: begin
                if (in_valid && in_ready) begin
                    acc_n = acc_sum;
                    cnt_n = cnt + CNT_W'(1);
                    // Operand and flags are prepared here so they are on the
                    // registered outputs during the issue cycle itself.
                    if (cnt == LAST_IDX) begin
                        state_n = S_SQ_ISSUE;
                        din_n   = acc_sum_sat ? SAT_MAX : acc_sum[DATA_W-1:0];
                        sat_n   = acc_sum_sat;
                        div0_n  = (acc_sum == '0);
                    end
                end
            end
            S_SQ_ISSUE: begin
                state_n = S_SQ_WAIT;
                wcnt_n  = WAIT_W'(1);
            end
            S_SQ_WAIT: begin
                if (wcnt == SQ_DONE_CNT) begin
                    norm_n = cordic_dout;
`ifdef COL_NORM_INV_EN
                    if (div0_w) begin
                        inv_n   = SAT_MAX;
                        state_n = S_DONE;
                    end else begin
                        din_n   = cordic_dout;
                        state_n = S_DV_ISSUE;
                    end
`else
                    state_n = S_DONE;
`endif
                end else begin
                    wcnt_n = wcnt + WAIT_W'(1);
                end
            end
`ifdef COL_NORM_INV_EN
            S_DV_ISSUE: begin
                state_n = S_DV_WAIT;
                wcnt_n  = WAIT_W'(1);
            end
            S_DV_WAIT: begin
                if (wcnt == DV_DONE_CNT) begin
                    inv_n   = cordic_dout;
                    state_n = S_DONE;
                end else begin
                    wcnt_n = wcnt + WAIT_W'(1);
                end
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

`ifdef COL_NORM_INV_EN
    assign dv_phase = (state_n == S_DV_ISSUE) || (state_n == S_DV_WAIT);
`else
    assign inv_norm_out      = '0;
    assign cordic_sel        = 1'b0;
    assign cordic_result_sel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            acc          <= '0;
            cnt          <= '0;
            wcnt         <= '0;
            sat_w        <= 1'b0;
            div0_w       <= 1'b0;
            norm_r       <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            norm_out     <= '0;
            sat_flag     <= 1'b0;
            div0_flag    <= 1'b0;
            cordic_en    <= 1'b0;
            cordic_din   <= '0;
`ifdef COL_NORM_INV_EN
            inv_r             <= '0;
            inv_norm_out      <= '0;
            cordic_sel        <= 1'b0;
            cordic_result_sel <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            wcnt       <= wcnt_n;
            sat_w      <= sat_n;
            div0_w     <= div0_n;
            norm_r     <= norm_n;
            in_ready   <= (state_n == S_ACC);
            busy       <= (state_n != S_IDLE);
            done       <= (state_n == S_DONE);
            cordic_en  <= (state_n == S_SQ_ISSUE) || (state_n == S_DV_ISSUE);
            cordic_din <= din_n;
            // Results and flags change together, only when done pulses.
            if (state_n == S_DONE) begin
                norm_out  <= norm_n;
                sat_flag  <= sat_n;
                div0_flag <= div0_n;
`ifdef COL_NORM_INV_EN
                inv_norm_out <= inv_n;
`endif
            end
`ifdef COL_NORM_INV_EN
            inv_r             <= inv_n;
            cordic_sel        <= dv_phase;
            cordic_result_sel <= dv_phase;
`endif
        end
    end

endmodule

// File: tb/tb_col_norm_seq.sv
// tb/tb_col_norm_seq.sv - randomized self-checking bench for col_norm_seq with a behavioural CORDIC model
module tb_col_norm_seq;

    localparam int DATA_W   = 19;
    localparam int FRAC     = 14;
    localparam int VEC_LEN  = 4;
    localparam int SQRT_LAT = 13;
    localparam int DIV_LAT  = 15;
    localparam longint DMAX = 262143;
`ifdef COL_NORM_INV_EN
    localparam bit INV_EN   = 1'b1;
    localparam int LAT_EXP  = VEC_LEN + SQRT_LAT + DIV_LAT + 3;
    localparam int INV_P1   = 8192;
    localparam int INV_M05  = 16384;
    localparam int INV_Z    = 262143;
`else
    localparam bit INV_EN   = 1'b0;
    localparam int LAT_EXP  = VEC_LEN + SQRT_LAT + 2;
    localparam int INV_P1   = 0;
    localparam int INV_M05  = 0;
    localparam int INV_Z    = 0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     busy;
    logic                     done;
    logic [DATA_W-1:0]        norm_out;
    logic [DATA_W-1:0]        inv_norm_out;
    logic                     sat_flag;
    logic                     div0_flag;
    logic                     cordic_en;
    logic                     cordic_sel;
    logic                     cordic_result_sel;
    logic [DATA_W-1:0]        cordic_din;
    logic [DATA_W-1:0]        cordic_dout;

    col_norm_seq #(
        .DATA_W  (DATA_W),
        .FRAC    (FRAC),
        .VEC_LEN (VEC_LEN),
        .SQRT_LAT(SQRT_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .busy             (busy),
        .done             (done),
        .norm_out         (norm_out),
        .inv_norm_out     (inv_norm_out),
        .sat_flag         (sat_flag),
        .div0_flag        (div0_flag),
        .cordic_en        (cordic_en),
        .cordic_sel       (cordic_sel),
        .cordic_result_sel(cordic_result_sel),
        .cordic_din       (cordic_din),
        .cordic_dout      (cordic_dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp);
        longint d;
        d = obs - exp;
        check(tag, (d >= -4 && d <= 4) ? exp : obs, exp);
    endtask

    // Ideal Q14 CORDIC: sqrt(x) = isqrt(x * 2^14), 1/x = 2^28 / x, saturating.
    function automatic longint f_sqrt(input longint d);
        longint x, r, c;
        x = d * 16384;
        r = 0;
        for (int b = 17; b >= 0; b--) begin
            c = r + (longint'(1) << b);
            if (c * c <= x) r = c;
        end
        return r;
    endfunction

    function automatic longint f_div(input longint d);
        longint q;
        if (d <= 0) return DMAX;
        q = (longint'(1) << 28) / d;
        return (q > DMAX) ? DMAX : q;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint exp_din, exp_norm, exp_inv;
    longint exp_sat, exp_div0;
    int     pend_at = -1;
    logic [DATA_W-1:0] pend_val = '0;
    int     en_cnt = 0;
    int     done_cnt = 0;
    int     sel_rises = 0;
    logic   sel_prev = 1'b0;

    // CORDIC model: result appears exactly LAT cycles after issue, noise otherwise.
    always @(negedge clk) begin
        if (rst_n && cordic_en) begin
            en_cnt <= en_cnt + 1;
            if (cordic_sel) begin
                check("dv_din", cordic_din, exp_norm);
                check("dv_rsel", cordic_result_sel, 1);
                pend_at  <= cyc + DIV_LAT;
                pend_val <= DATA_W'(f_div(longint'(cordic_din)));
            end else begin
                check("sq_din", cordic_din, exp_din);
                check("sq_rsel", cordic_result_sel, 0);
                pend_at  <= cyc + SQRT_LAT;
                pend_val <= DATA_W'(f_sqrt(longint'(cordic_din)));
            end
        end
        cordic_dout <= (cyc == pend_at) ? pend_val : DATA_W'($urandom);
        if (done) done_cnt <= done_cnt + 1;
        if (cordic_sel && !sel_prev) sel_rises <= sel_rises + 1;
        sel_prev <= cordic_sel;
    end

    logic signed [DATA_W-1:0] smp [VEC_LEN];

    task automatic compute_expected();
        longint sum, sv;
        sum = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            sv  = longint'(smp[i]);
            sum += (sv * sv) >>> FRAC;
        end
        exp_sat  = (sum > DMAX) ? 1 : 0;
        exp_div0 = (sum == 0) ? 1 : 0;
        exp_din  = (sum > DMAX) ? DMAX : sum;
        exp_norm = f_sqrt(exp_din);
        exp_inv  = !INV_EN ? 0 : (exp_div0 != 0) ? DMAX : f_div(exp_norm);
    endtask

    // gaps: 0 none, 1 alternating 1010, 2 random; abort_after > 0 resets that many cycles after the SQ issue.
    task automatic run_vec(input int gaps, input bit mid_start, input int abort_after);
        int     idx, n, k, t0, en0, d0, s0;
        bit     v, accepted;
        compute_expected();
        en0 = en_cnt;
        d0  = done_cnt;
        s0  = sel_rises;
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        t0       = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_acc", busy, 1);
        idx = 0;
        n   = 0;
        while (idx < VEC_LEN && n < 200) begin
            v        = (gaps == 0) ? 1'b1 : (gaps == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? smp[idx] : DATA_W'($urandom);
            start    = mid_start && (n == 2);
            accepted = v && in_ready;
            @(negedge clk);
            if (accepted) idx++;
            n++;
        end
        start = 1'b0;
        check("accept_cnt", idx, VEC_LEN);
        check("rdy_drop", in_ready, 0);
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            check("busy_wait", busy, 1);
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rdy", in_ready, 0);
            check("rst_norm", norm_out, 0);
            check("rst_inv", inv_norm_out, 0);
            check("rst_flags", {sat_flag, div0_flag}, 0);
            check("rst_cordic", {cordic_en, cordic_sel, cordic_result_sel, cordic_din}, 0);
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (40) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_idle", busy, 0);
            check("abort_en", en_cnt - en0, 1);
            return;
        end
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("done_seen", done, 1);
        if (gaps == 0 && !mid_start) check("latency", cyc - t0, LAT_EXP);
        check("norm", norm_out, exp_norm);
        check("inv", inv_norm_out, exp_inv);
        check("sat", sat_flag, exp_sat);
        check("div0", div0_flag, exp_div0);
        check("busy_done", busy, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle", busy, 0);
        check("norm_hold", norm_out, exp_norm);
        check("en_pulses", en_cnt - en0, (INV_EN && exp_div0 == 0) ? 2 : 1);
        check("sel_rises", sel_rises - s0, (INV_EN && exp_div0 == 0) ? 1 : 0);
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < VEC_LEN; i++) smp[i] = DATA_W'(val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        exp_din  = 0;
        exp_norm = 0;
        exp_inv  = 0;
        exp_sat  = 0;
        exp_div0 = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_outs", {in_ready, done, sat_flag, div0_flag, cordic_en, norm_out, inv_norm_out, cordic_din}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill(16384);
        run_vec(0, 1'b0, 0);
        check("p1_din", exp_din, 65536);
        check_near("p1_norm", norm_out, 32768);
        check_near("p1_inv", inv_norm_out, INV_P1);

        fill(-8192);
        run_vec(0, 1'b0, 0);
        check_near("m05_norm", norm_out, 16384);
        check_near("m05_inv", inv_norm_out, INV_M05);

        fill(49152);
        run_vec(0, 1'b0, 0);
        check("sat3_flag", sat_flag, 1);
        check_near("sat3_norm", norm_out, 65535);

        fill(0);
        run_vec(0, 1'b0, 0);
        check("zero_div0", div0_flag, 1);
        check_near("zero_norm", norm_out, 0);
        check("zero_inv", inv_norm_out, INV_Z);

        for (int i = 0; i < VEC_LEN; i++) smp[i] = DATA_W'(int'($urandom_range(0, 32767)) - 16384);
        run_vec(1, 1'b1, 4);

        fill(16384);
        run_vec(0, 1'b0, 0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                case ($urandom_range(0, 2))
                    0:       smp[i] = DATA_W'(int'($urandom_range(0, 4095)) - 2048);
                    1:       smp[i] = DATA_W'($urandom);
                    default: smp[i] = DATA_W'(int'($urandom_range(0, 3)) - 1);
                endcase
            end
            run_vec(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
